// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: EX-side checker for fetch-stage branch predictions.
// Each prediction issued at fetch ({pc, taken, target}) waits in a small FIFO
// until the matching branch/jump resolves in EX. The resolution is compared
// against the head entry, or against an implicit "not taken" prediction when
// the head does not match. The block emits a registered predictor-table update
// and a one-cycle redirect on mispredict. A mispredict or a pipeline flush
// discards all wrong-path entries.
// Optional feature macro: BP_RESOLVE_STATS_EN adds saturating counters of
// resolved conditional branches and mispredicts (stat_branches_o,
// stat_mispredicts_o).
module bp_resolve_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    output logic        pred_ready_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_cond_i,
    input  logic        ex_compressed_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        flush_i,
    output logic [31:0] ex_br_instr_addr_o,
    output logic        ex_br_taken_o,
    output logic        ex_br_valid_o,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
`ifdef BP_RESOLVE_STATS_EN
   ,output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(0);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Prediction storage, one slot per in-flight branch.
    logic [31:0]   pc_mem_r     [DEPTH];
    logic          taken_mem_r  [DEPTH];
    logic [31:0]   target_mem_r [DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;
    logic          ready_r;

    logic [31:0]   br_addr_r;
    logic          br_taken_r;
    logic          br_valid_r;
    logic          mispredict_r;
    logic [31:0]   redirect_pc_r;

    logic          head_match_s;
    logic          cmp_taken_s;
    logic [31:0]   cmp_target_s;
    logic          mispred_s;
    logic          clear_s;
    logic          push_s;
    logic          pop_s;
    logic [PW:0]   count_next_s;
    logic [31:0]   fallthru_pc_s;
    logic [31:0]   redirect_next_s;

    // Resolution compare against the head (or implicit not-taken) and queue control.
    always_comb begin
        head_match_s    = 1'b0;
        cmp_taken_s     = 1'b0;
        cmp_target_s    = 32'h0000_0000;
        mispred_s       = 1'b0;
        clear_s         = 1'b0;
        push_s          = 1'b0;
        pop_s           = 1'b0;
        count_next_s    = count_r;
        fallthru_pc_s   = 32'h0000_0000;
        redirect_next_s = 32'h0000_0000;

        if (ex_valid_i && (count_r != CNT_ZERO) && (pc_mem_r[head_r] == ex_pc_i)) begin
            head_match_s = 1'b1;
            cmp_taken_s  = taken_mem_r[head_r];
            cmp_target_s = target_mem_r[head_r];
        end else begin
            head_match_s = 1'b0;
            cmp_taken_s  = 1'b0;
            cmp_target_s = 32'h0000_0000;
        end

        if (ex_valid_i) begin
            mispred_s = (ex_taken_i != cmp_taken_s) |
                        (ex_taken_i & cmp_taken_s & (ex_target_i != cmp_target_s));
        end else begin
            mispred_s = 1'b0;
        end

        fallthru_pc_s   = ex_pc_i + (ex_compressed_i ? 32'd2 : 32'd4);
        redirect_next_s = ex_taken_i ? ex_target_i : fallthru_pc_s;

        // Wrong-path entries die with a mispredict or flush, including any
        // prediction arriving in the same cycle.
        clear_s = mispred_s | flush_i;
        push_s  = pred_valid_i & ready_r & ~clear_s;
        pop_s   = head_match_s & ~clear_s;

        if (clear_s) begin
            count_next_s = CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Queue pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            ready_r <= 1'b1;
        end else begin
            if (clear_s) begin
                head_r <= PTR_ZERO;
                tail_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
            end
            count_r <= count_next_s;
            // Ready follows occupancy only; a pop never frees a slot for a same-cycle push.
            ready_r <= (count_next_s != FULL_CNT);
        end
    end

    // Prediction payload storage written at the tail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]     <= 32'h0000_0000;
                taken_mem_r[i]  <= 1'b0;
                target_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]     <= pred_pc_i;
            taken_mem_r[tail_r]  <= pred_taken_i;
            target_mem_r[tail_r] <= pred_target_i;
        end else begin
            pc_mem_r[tail_r]     <= pc_mem_r[tail_r];
            taken_mem_r[tail_r]  <= taken_mem_r[tail_r];
            target_mem_r[tail_r] <= target_mem_r[tail_r];
        end
    end

    // Registered predictor update and redirect outputs (one cycle after resolve).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_addr_r     <= 32'h0000_0000;
            br_taken_r    <= 1'b0;
            br_valid_r    <= 1'b0;
            mispredict_r  <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            br_addr_r    <= ex_pc_i;
            br_taken_r   <= ex_taken_i;
            br_valid_r   <= ex_valid_i & ex_cond_i;
            mispredict_r <= mispred_s;
            if (mispred_s) begin
                redirect_pc_r <= redirect_next_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    assign pred_ready_o       = ready_r;
    assign ex_br_instr_addr_o = br_addr_r;
    assign ex_br_taken_o      = br_taken_r;
    assign ex_br_valid_o      = br_valid_r;
    assign mispredict_o       = mispredict_r;
    assign redirect_pc_o      = redirect_pc_r;

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_br_r;
    logic [31:0] stat_mis_r;

    // Saturating event counters for resolved conditional branches and mispredicts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_br_r  <= 32'h0000_0000;
            stat_mis_r <= 32'h0000_0000;
        end else begin
            if (ex_valid_i && ex_cond_i && (stat_br_r != 32'hFFFF_FFFF)) begin
                stat_br_r <= stat_br_r + 32'd1;
            end else begin
                stat_br_r <= stat_br_r;
            end
            if (mispred_s && (stat_mis_r != 32'hFFFF_FFFF)) begin
                stat_mis_r <= stat_mis_r + 32'd1;
            end else begin
                stat_mis_r <= stat_mis_r;
            end
        end
    end

    assign stat_branches_o    = stat_br_r;
    assign stat_mispredicts_o = stat_mis_r;
`endif

endmodule
